// File: rtl/ob_cmd_sched.sv
// ob_cmd_sched -- order-book command scheduler.
//
// Pops one command at a time from the ingress queue, issues it to the bid
// and/or ask table, waits for the table acknowledge (with a timeout), and
// pushes a single response to the egress queue.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cmd_empty_i, cmd_opcode_i,
//   cmd_uid_i/qty_i/price_i        head of ingress queue
//   cmd_pop_o                      pop head of ingress queue
//   bid_req_vld_o, ask_req_vld_o   request strobes to bid / ask table
//   tbl_req_op/uid/qty/price_o     request fields shared by both tables
//   bid_ack_i/hit_i, ask_ack_i/hit_i  table acknowledge and hit flag
//   rsp_full_i, rsp_push_o,
//   rsp_uid_o, rsp_status_o        egress queue handshake and response
//   busy_o                         scheduler not idle
//   cmd_cnt_o                      saturating count of responses pushed
module ob_cmd_sched #(
  parameter int UID_W   = 8,
  parameter int QTY_W   = 16,
  parameter int PRICE_W = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_empty_i,
  input  logic [1:0]         cmd_opcode_i,
  input  logic [UID_W-1:0]   cmd_uid_i,
  input  logic [QTY_W-1:0]   cmd_qty_i,
  input  logic [PRICE_W-1:0] cmd_price_i,
  output logic               cmd_pop_o,
  output logic               bid_req_vld_o,
  output logic               ask_req_vld_o,
  output logic [1:0]         tbl_req_op_o,
  output logic [UID_W-1:0]   tbl_req_uid_o,
  output logic [QTY_W-1:0]   tbl_req_qty_o,
  output logic [PRICE_W-1:0] tbl_req_price_o,
  input  logic               bid_ack_i,
  input  logic               bid_hit_i,
  input  logic               ask_ack_i,
  input  logic               ask_hit_i,
  input  logic               rsp_full_i,
  output logic               rsp_push_o,
  output logic [UID_W-1:0]   rsp_uid_o,
  output logic [1:0]         rsp_status_o,
  output logic               busy_o,
  output logic [15:0]        cmd_cnt_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE_BID = 2'd1;
  localparam logic [1:0] ST_ISSUE_ASK = 2'd2;
  localparam logic [1:0] ST_RSP       = 2'd3;

  localparam logic [1:0] OPC_NOP    = 2'd0;
  localparam logic [1:0] OPC_BUY    = 2'd1;
  localparam logic [1:0] OPC_SELL   = 2'd2;
  localparam logic [1:0] OPC_CANCEL = 2'd3;

  localparam logic [1:0] TBL_NONE   = 2'd0;
  localparam logic [1:0] TBL_INSERT = 2'd1;
  localparam logic [1:0] TBL_CANCEL = 2'd2;

  localparam logic [1:0] RS_OK       = 2'd0;
  localparam logic [1:0] RS_REJECT   = 2'd1;
  localparam logic [1:0] RS_NOTFOUND = 2'd2;
  localparam logic [1:0] RS_TIMEOUT  = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [UID_W-1:0]   uid_q, uid_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [1:0]         status_q, status_d;
  logic [7:0]         tmo_q, tmo_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               zero_qty_s;

  assign zero_qty_s = (cmd_qty_i == {QTY_W{1'b0}});

  // Next-state, latched-field, timeout and response-counter logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    uid_d    = uid_q;
    qty_d    = qty_q;
    price_d  = price_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty_i) begin
          uid_d   = cmd_uid_i;
          qty_d   = cmd_qty_i;
          price_d = cmd_price_i;
          tmo_d   = 8'd0;
          case (cmd_opcode_i)
            OPC_BUY, OPC_SELL: begin
              if (zero_qty_s) begin
                // Zero quantity never reaches a table.
                op_d     = TBL_NONE;
                status_d = RS_REJECT;
                state_d  = ST_RSP;
              end else begin
                op_d    = TBL_INSERT;
                state_d = (cmd_opcode_i == OPC_BUY) ? ST_ISSUE_BID : ST_ISSUE_ASK;
              end
            end
            OPC_CANCEL: begin
              // Cancel probes the bid table first, then the ask table.
              op_d    = TBL_CANCEL;
              state_d = ST_ISSUE_BID;
            end
            default: begin
              op_d     = TBL_NONE;
              status_d = RS_OK;
              state_d  = ST_RSP;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE_BID: begin
        // Ack wins over a timeout landing in the same cycle.
        if (bid_ack_i) begin
          if (op_q == TBL_CANCEL) begin
            if (bid_hit_i) begin
              status_d = RS_OK;
              state_d  = ST_RSP;
            end else begin
              tmo_d   = 8'd0;
              state_d = ST_ISSUE_ASK;
            end
          end else begin
            status_d = bid_hit_i ? RS_OK : RS_REJECT;
            state_d  = ST_RSP;
          end
        end else if (tmo_q == TMO_LAST) begin
          status_d = RS_TIMEOUT;
          state_d  = ST_RSP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_ISSUE_ASK: begin
        if (ask_ack_i) begin
          if (op_q == TBL_CANCEL) begin
            status_d = ask_hit_i ? RS_OK : RS_NOTFOUND;
          end else begin
            status_d = ask_hit_i ? RS_OK : RS_REJECT;
          end
          state_d = ST_RSP;
        end else if (tmo_q == TMO_LAST) begin
          status_d = RS_TIMEOUT;
          state_d  = ST_RSP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_RSP: begin
        if (!rsp_full_i) begin
          state_d = ST_IDLE;
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched command registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      op_q     <= TBL_NONE;
      uid_q    <= {UID_W{1'b0}};
      qty_q    <= {QTY_W{1'b0}};
      price_q  <= {PRICE_W{1'b0}};
      status_q <= RS_OK;
      tmo_q    <= 8'd0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      uid_q    <= uid_d;
      qty_q    <= qty_d;
      price_q  <= price_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  // cmd_pop is gated by rst_ni so it stays low while reset is asserted.
  assign cmd_pop_o       = rst_ni && (state_q == ST_IDLE) && !cmd_empty_i;
  assign bid_req_vld_o   = (state_q == ST_ISSUE_BID);
  assign ask_req_vld_o   = (state_q == ST_ISSUE_ASK);
  assign tbl_req_op_o    = op_q;
  assign tbl_req_uid_o   = uid_q;
  assign tbl_req_qty_o   = qty_q;
  assign tbl_req_price_o = price_q;
  assign rsp_push_o      = (state_q == ST_RSP) && !rsp_full_i;
  assign rsp_uid_o       = uid_q;
  assign rsp_status_o    = status_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign cmd_cnt_o       = cnt_q;

endmodule
